// File: rtl/reg_bus_master_pkg.sv
// Shared types and sizes for the register-file bus-master sequencer.
// Command opcodes, FSM state encoding and bus/index widths live here.
package reg_bus_master_pkg;

  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_MOV  = 2'b10,
    OP_READ = 2'b11
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_WR,
    ST_RD,
    ST_TURN,
    ST_WR,
    ST_RSP
  } bus_mst_state_e;

endpackage

// File: rtl/reg_bus_master_if.sv
// Command, response and register-file/data-bus signals of the bus master.
// The master modport is the sequencer's view; slave is the environment's view.
interface reg_bus_master_if;
  import reg_bus_master_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src;
  logic [DW-1:0] cmd_imm;

  logic [AW-1:0] reg_sel;
  logic          reg_oe;
  logic          reg_wen;
  logic          bus_oe;
  logic [DW-1:0] bus_out;
  logic [DW-1:0] bus_in;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bus_in, rsp_ready,
    output cmd_ready, reg_sel, reg_oe, reg_wen, bus_oe, bus_out,
           rsp_valid, rsp_data, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bus_in, rsp_ready,
    input  cmd_ready, reg_sel, reg_oe, reg_wen, bus_oe, bus_out,
           rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/reg_bus_master.sv
// Sequencer that turns LOAD/MOV/READ commands into register-file strobes.
// All strobes decode from registered state so cmd_* never reaches them combinationally.
module reg_bus_master
  import reg_bus_master_pkg::*;
(
  input logic              clk,
  input logic              rst,
  reg_bus_master_if.master bus
);

  bus_mst_state_e state_q, state_d;
  bus_op_e        op_q, op_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [AW-1:0]  src_q, src_d;
  logic [DW-1:0]  imm_q, imm_d;
  logic [DW-1:0]  hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      dst_q   <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    dst_d         = dst_q;
    src_d         = src_q;
    imm_d         = imm_q;
    hold_d        = hold_q;
    bus.cmd_ready = 1'b0;
    bus.reg_sel   = '0;
    bus.reg_oe    = 1'b0;
    bus.reg_wen   = 1'b0;
    bus.bus_oe    = 1'b0;
    bus.bus_out   = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d  = bus_op_e'(bus.cmd_op);
          dst_d = bus.cmd_dst;
          src_d = bus.cmd_src;
          imm_d = bus.cmd_imm;
          case (bus_op_e'(bus.cmd_op))
            OP_LOAD:         state_d = ST_LD_WR;
            OP_MOV, OP_READ: state_d = ST_RD;
            default:         state_d = ST_IDLE;
          endcase
        end
      end

      ST_LD_WR: begin
        bus.bus_oe  = 1'b1;
        bus.bus_out = imm_q;
        bus.reg_sel = dst_q;
        bus.reg_wen = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_RD: begin
        bus.reg_oe  = 1'b1;
        bus.reg_sel = src_q;
        hold_d      = bus.bus_in;
        state_d     = (op_q == OP_MOV) ? ST_TURN : ST_RSP;
      end

      // Dead cycle so the register file releases the bus before we drive it.
      ST_TURN: state_d = ST_WR;

      ST_WR: begin
        bus.bus_oe  = 1'b1;
        bus.bus_out = hold_q;
        bus.reg_sel = dst_q;
        bus.reg_wen = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = hold_q;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed cycle checks, randomized command traffic,
// a command-level register model and a response scoreboard.
module tb_reg_bus_master;

  logic clk;
  logic rst;
  logic env_clr;
  logic rand_rsp;

  reg_bus_master_if bus_if();

  reg_bus_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] env_regs [8];
  logic [7:0] ref_regs [8];
  logic [7:0] exp_q [$];
  logic [7:0] bus_val;

  // Register file plus resolved data bus seen by the DUT.
  assign bus_val = bus_if.reg_oe ? env_regs[bus_if.reg_sel] :
                   bus_if.bus_oe ? bus_if.bus_out : 8'h00;
  assign bus_if.bus_in = bus_val;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) env_regs[i] <= 8'h00;
    end else if (bus_if.reg_wen) begin
      env_regs[bus_if.reg_sel] <= bus_val;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pk(logic rdy, logic bsy, logic [2:0] sel, logic oe,
                                     logic wen, logic boe, logic [7:0] bo,
                                     logic rv, logic [7:0] rd);
    return {rdy, bsy, sel, oe, wen, boe, bo, rv, rd};
  endfunction

  function automatic logic [24:0] outs();
    return pk(bus_if.cmd_ready, bus_if.busy, bus_if.reg_sel, bus_if.reg_oe,
              bus_if.reg_wen, bus_if.bus_oe, bus_if.bus_out,
              bus_if.rsp_valid, bus_if.rsp_data);
  endfunction

  localparam logic [24:0] IDLE_O = 25'h1000000;

  // Monitor: bus invariants, response scoreboard, response stability.
  logic       prev_rv;
  logic       prev_hs;
  logic [7:0] prev_rd;
  initial begin
    prev_rv = 1'b0;
    prev_hs = 1'b0;
    prev_rd = 8'h00;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      logic bad;
      bad = (bus_if.reg_oe && bus_if.bus_oe) || (bus_if.reg_oe && bus_if.reg_wen) ||
            (!bus_if.reg_oe && !bus_if.reg_wen && !bus_if.bus_oe &&
             (bus_if.reg_sel != 3'd0 || bus_if.bus_out != 8'h00));
      chk("bus_invariant", {31'd0, bad}, 32'd0);
      if (bus_if.rsp_valid && prev_rv && !prev_hs)
        chk("rsp_stable", {24'd0, bus_if.rsp_data}, {24'd0, prev_rd});
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", {24'd0, bus_if.rsp_data}, {24'd0, e});
        end
      end
      prev_rv = bus_if.rsp_valid;
      prev_hs = bus_if.rsp_valid && bus_if.rsp_ready;
      prev_rd = bus_if.rsp_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for acceptance, updates the reference model at the accept edge,
  // and returns one cycle after that edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] imm);
    int t;
    t = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_dst   = dst;
    bus_if.cmd_src   = src;
    bus_if.cmd_imm   = imm;
    while (!bus_if.cmd_ready && t < 200) begin
      if (rand_rsp) bus_if.rsp_ready = 1'($urandom_range(0, 1));
      cyc();
      t++;
    end
    if (!bus_if.cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    case (op)
      2'b01: ref_regs[dst] = imm;
      2'b10: ref_regs[dst] = ref_regs[src];
      2'b11: exp_q.push_back(ref_regs[src]);
      default: ;
    endcase
    cyc();
    bus_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    env_clr          = 1'b1;
    rand_rsp         = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_dst   = 3'd0;
    bus_if.cmd_src   = 3'd0;
    bus_if.cmd_imm   = 8'h00;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    cyc();
    cyc();
    rst     = 1'b0;
    env_clr = 1'b0;
    chk("reset_outputs", {7'd0, outs()}, {7'd0, IDLE_O});

    // LOAD r3 <- A5, strobe one cycle after accept
    issue(2'b01, 3'd3, 3'd0, 8'hA5);
    chk("load_wr", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00)});
    cyc();
    chk("load_idle", {7'd0, outs()}, {7'd0, IDLE_O});

    // READ r3 back with consumer ready
    bus_if.rsp_ready = 1'b1;
    issue(2'b11, 3'd0, 3'd3, 8'h00);
    chk("read_rd", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)});
    cyc();
    chk("read_rsp", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5)});
    cyc();
    chk("read_idle", {7'd0, outs()}, {7'd0, IDLE_O});
    bus_if.rsp_ready = 1'b0;

    // MOV r6 <- r1 (3C)
    issue(2'b01, 3'd1, 3'd0, 8'h3C);
    issue(2'b10, 3'd6, 3'd1, 8'h00);
    chk("mov_rd", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)});
    cyc();
    chk("mov_turn", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)});
    cyc();
    chk("mov_wr", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00)});
    cyc();
    chk("mov_idle", {7'd0, outs()}, {7'd0, IDLE_O});

    // MOV with src == dst runs the whole sequence
    issue(2'b10, 3'd6, 3'd6, 8'h00);
    cyc();
    cyc();
    chk("mov_same_wr", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00)});

    // READ r2 (7E) with the consumer stalling for 5 cycles
    issue(2'b01, 3'd2, 3'd0, 8'h7E);
    issue(2'b11, 3'd0, 3'd2, 8'h00);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("read_stall", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h7E)});
    end
    bus_if.rsp_ready = 1'b1;
    cyc();
    bus_if.rsp_ready = 1'b0;
    chk("read_release", {7'd0, outs()}, {7'd0, IDLE_O});

    // Reset during TURN of a MOV aborts the write to r4
    issue(2'b01, 3'd4, 3'd0, 8'h11);
    cyc();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'b10;
    bus_if.cmd_dst   = 3'd4;
    bus_if.cmd_src   = 3'd1;
    cyc();
    bus_if.cmd_valid = 1'b0;
    cyc();
    chk("abort_turn", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_idle", {7'd0, outs()}, {7'd0, IDLE_O});
    cyc();
    cyc();
    cyc();
    chk("abort_no_write", {24'd0, env_regs[4]}, 32'h11);

    // NOP then LOAD on consecutive IDLE cycles with cmd_valid held high
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'b00;
    cyc();
    chk("nop_accept", {7'd0, outs()}, {7'd0, IDLE_O});
    bus_if.cmd_op  = 2'b01;
    bus_if.cmd_dst = 3'd5;
    bus_if.cmd_imm = 8'h5A;
    ref_regs[5]    = 8'h5A;
    cyc();
    bus_if.cmd_valid = 1'b0;
    chk("b2b_load", {7'd0, outs()}, {7'd0, pk(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00)});
    cyc();

    // Randomized traffic with random consumer back-pressure
    rand_rsp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus_if.rsp_ready = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    rand_rsp         = 1'b0;
    bus_if.rsp_ready = 1'b1;
    for (int t = 0; t < 20 && !bus_if.cmd_ready; t++) cyc();
    chk("drain_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
    cyc();
    for (int i = 0; i < 8; i++) chk($sformatf("regfile_r%0d", i), {24'd0, env_regs[i]}, {24'd0, ref_regs[i]});
    chk("rsp_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
